// File: rtl/span_pkg.sv
// Shared types and defaults for the SPAN margin sequencer.
package span_pkg;

    localparam int DEFAULT_DW             = 16;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SR_START,
        ST_SR_WAIT,
        ST_IMS_START,
        ST_IMS_WAIT,
        ST_SUM,
        ST_DONE,
        ST_ERR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'b00,
        ERR_SR_TO  = 2'b01,
        ERR_IMS_TO = 2'b10
    } err_code_t;

    // IDLE, DONE and ERR are the resting states in which a new start is accepted.
    function automatic logic is_busy_state(input state_t s);
        return !(s inside {ST_IDLE, ST_DONE, ST_ERR});
    endfunction

endpackage

// File: rtl/span_calc_ctrl_if.sv
// Host command, engine handshake and result signals of the SPAN sequencer.
interface span_calc_ctrl_if
    import span_pkg::*;
#(
    parameter int DW = DEFAULT_DW
);

    logic            cmd_start;
    logic            cmd_abort;
    logic            sr_start;
    logic            sr_done;
    logic [DW-1:0]   sr_result;
    logic            ims_start;
    logic            ims_done;
    logic [DW-1:0]   ims_result;
    logic [DW-1:0]   margin;
    logic            margin_valid;
    logic            busy;
    logic            overflow;
    logic            err;
    err_code_t       err_code;
    logic            busy_reject;

    modport master (
        input  cmd_start, cmd_abort, sr_done, sr_result, ims_done, ims_result,
        output sr_start, ims_start, margin, margin_valid, busy, overflow,
               err, err_code, busy_reject
    );

    modport slave (
        output cmd_start, cmd_abort, sr_done, sr_result, ims_done, ims_result,
        input  sr_start, ims_start, margin, margin_valid, busy, overflow,
               err, err_code, busy_reject
    );

endinterface

// File: rtl/span_wait_timer.sv
// Wait-state watchdog counter shared by the scan-risk and spread engine waits.
module span_wait_timer #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CW             = $clog2(TIMEOUT_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CW-1:0] count;

    // Holds at the terminal count; the sequencer leaves the wait state on that edge.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/span_calc_ctrl.sv
// SPAN margin sequencer: scan-risk engine, then spread engine, then saturating sum.
module span_calc_ctrl
    import span_pkg::*;
#(
    parameter int DW             = DEFAULT_DW,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CW             = $clog2(TIMEOUT_CYCLES)
) (
    input  logic             clk,
    input  logic             reset,
    span_calc_ctrl_if.master bus
);

    state_t        state;
    err_code_t     err_code_q;
    logic [DW-1:0] sr_latched;
    logic [DW-1:0] ims_latched;
    logic [DW-1:0] margin_q;
    logic          margin_valid_q;
    logic          overflow_q;
    logic          err_q;
    logic          busy_reject_q;
    logic          busy;
    logic [DW:0]   full_sum;
    logic          timer_clear;
    logic          timer_enable;
    logic          timer_expired;

    assign busy     = is_busy_state(state);
    assign full_sum = {1'b0, sr_latched} + {1'b0, ims_latched};

    // The timer restarts in each START state so both waits get the full budget.
    assign timer_clear  = bus.cmd_abort || (state == ST_SR_START) || (state == ST_IMS_START);
    assign timer_enable = ((state == ST_SR_WAIT) && !bus.sr_done) ||
                          ((state == ST_IMS_WAIT) && !bus.ims_done);

    span_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CW             (CW)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    // Abort outranks every state transition, including a same-cycle start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            sr_latched     <= '0;
            ims_latched    <= '0;
            margin_q       <= '0;
            margin_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
            err_q          <= 1'b0;
            err_code_q     <= ERR_NONE;
            busy_reject_q  <= 1'b0;
        end else if (bus.cmd_abort) begin
            state          <= ST_IDLE;
            margin_valid_q <= 1'b0;
            err_q          <= 1'b0;
            err_code_q     <= ERR_NONE;
        end else begin
            if (bus.cmd_start && busy) begin
                busy_reject_q <= 1'b1;
            end
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (bus.cmd_start) begin
                        state          <= ST_SR_START;
                        margin_valid_q <= 1'b0;
                        overflow_q     <= 1'b0;
                        err_q          <= 1'b0;
                        err_code_q     <= ERR_NONE;
                        busy_reject_q  <= 1'b0;
                    end
                end
                ST_SR_START: begin
                    state <= ST_SR_WAIT;
                end
                ST_SR_WAIT: begin
                    if (bus.sr_done) begin
                        sr_latched <= bus.sr_result;
                        state      <= ST_IMS_START;
                    end else if (timer_expired) begin
                        state      <= ST_ERR;
                        err_q      <= 1'b1;
                        err_code_q <= ERR_SR_TO;
                    end
                end
                ST_IMS_START: begin
                    state <= ST_IMS_WAIT;
                end
                ST_IMS_WAIT: begin
                    if (bus.ims_done) begin
                        ims_latched <= bus.ims_result;
                        state       <= ST_SUM;
                    end else if (timer_expired) begin
                        state      <= ST_ERR;
                        err_q      <= 1'b1;
                        err_code_q <= ERR_IMS_TO;
                    end
                end
                ST_SUM: begin
                    margin_q       <= full_sum[DW] ? '1 : full_sum[DW-1:0];
                    overflow_q     <= full_sum[DW];
                    margin_valid_q <= 1'b1;
                    state          <= ST_DONE;
                end
            endcase
        end
    end

    assign bus.sr_start     = (state == ST_SR_START);
    assign bus.ims_start    = (state == ST_IMS_START);
    assign bus.margin       = margin_q;
    assign bus.margin_valid = margin_valid_q;
    assign bus.busy         = busy;
    assign bus.overflow     = overflow_q;
    assign bus.err          = err_q;
    assign bus.err_code     = err_code_q;
    assign bus.busy_reject  = busy_reject_q;

endmodule

// File: tb/tb_span_calc_ctrl.sv
// Directed scoreboard bench for span_calc_ctrl with a short engine timeout.
module tb_span_calc_ctrl;
    import span_pkg::*;

    localparam int DW = 16;
    localparam int TO = 8;

    typedef struct {
        logic [DW-1:0] margin;
        logic          overflow;
        logic          is_err;
        logic [1:0]    code;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    int obs_sr_start_at;
    int obs_ims_start_at;
    int obs_sr_pulses;
    int obs_ims_pulses;
    int obs_mv_at;
    int obs_err_at;
    int late_pulses;

    span_calc_ctrl_if #(.DW(DW)) bus ();

    span_calc_ctrl #(
        .DW             (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic exp_t model_sum(input logic [DW-1:0] a, input logic [DW-1:0] b);
        exp_t        e;
        logic [DW:0] full;
        full       = {1'b0, a} + {1'b0, b};
        e.overflow = full[DW];
        e.margin   = full[DW] ? {DW{1'b1}} : full[DW-1:0];
        e.is_err   = 1'b0;
        e.code     = 2'b00;
        return e;
    endfunction

    function automatic exp_t model_err(input logic [1:0] code);
        exp_t e;
        e.margin   = '0;
        e.overflow = 1'b0;
        e.is_err   = 1'b1;
        e.code     = code;
        return e;
    endfunction

    // Cycle c is the c-th rising edge after the run begins; cmd_start is sampled at c=0.
    // Observations made just after edge c are recorded as "at c+1".
    task automatic apply_stimulus(input int sr_at, input logic [DW-1:0] sr_val,
                                  input int ims_at, input logic [DW-1:0] ims_val,
                                  input int extra_start_at, input int abort_at,
                                  input int stray_sr_at, input int max_cycles);
        exp_t e;
        obs_sr_start_at  = -1;
        obs_ims_start_at = -1;
        obs_sr_pulses    = 0;
        obs_ims_pulses   = 0;
        obs_mv_at        = -1;
        obs_err_at       = -1;
        for (int c = 0; c < max_cycles; c++) begin
            bus.cmd_start  = (c == 0) || (c == extra_start_at);
            bus.cmd_abort  = (c == abort_at);
            bus.sr_done    = (c == sr_at) || (c == stray_sr_at);
            bus.sr_result  = (c == sr_at) ? sr_val : 16'hDEAD;
            bus.ims_done   = (c == ims_at);
            bus.ims_result = (c == ims_at) ? ims_val : 16'hBEEF;
            tick();
            if (bus.sr_start) begin
                obs_sr_pulses++;
                if (obs_sr_start_at < 0) obs_sr_start_at = c + 1;
            end
            if (bus.ims_start) begin
                obs_ims_pulses++;
                if (obs_ims_start_at < 0) obs_ims_start_at = c + 1;
            end
            if (bus.margin_valid || bus.err) begin
                if (bus.margin_valid) obs_mv_at = c + 1;
                else obs_err_at = c + 1;
                check_output("sb_result_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    if (e.is_err) begin
                        check_output("sb_err", bus.err, 1);
                        check_output("sb_err_code", bus.err_code, e.code);
                        check_output("sb_err_margin_valid", bus.margin_valid, 0);
                    end else begin
                        check_output("sb_margin", bus.margin, e.margin);
                        check_output("sb_overflow", bus.overflow, e.overflow);
                        check_output("sb_no_err", bus.err, 0);
                    end
                end
                break;
            end
        end
        bus.cmd_start = 1'b0;
        bus.cmd_abort = 1'b0;
        bus.sr_done   = 1'b0;
        bus.ims_done  = 1'b0;
        check_output("sb_drained", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        bus.cmd_start  = 1'b0;
        bus.cmd_abort  = 1'b0;
        bus.sr_done    = 1'b0;
        bus.sr_result  = '0;
        bus.ims_done   = 1'b0;
        bus.ims_result = '0;
        reset          = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        $display("[TB] reset state");
        check_output("rst_margin", bus.margin, 0);
        check_output("rst_margin_valid", bus.margin_valid, 0);
        check_output("rst_overflow", bus.overflow, 0);
        check_output("rst_err", bus.err, 0);
        check_output("rst_err_code", bus.err_code, 0);
        check_output("rst_busy_reject", bus.busy_reject, 0);
        check_output("rst_sr_start", bus.sr_start, 0);
        check_output("rst_ims_start", bus.ims_start, 0);
        check_output("rst_busy", bus.busy, 0);

        $display("[TB] nominal sequence");
        sb.push_back(model_sum(16'h0120, 16'h0034));
        apply_stimulus(2, 16'h0120, 4, 16'h0034, -1, -1, -1, 40);
        check_output("nom_sr_start_at", obs_sr_start_at, 1);
        check_output("nom_ims_start_at", obs_ims_start_at, 3);
        check_output("nom_mv_at", obs_mv_at, 6);
        check_output("nom_sr_pulses", obs_sr_pulses, 1);
        check_output("nom_ims_pulses", obs_ims_pulses, 1);
        check_output("nom_margin_abs", bus.margin, 16'h0154);
        check_output("nom_busy", bus.busy, 0);
        check_output("nom_busy_reject", bus.busy_reject, 0);

        $display("[TB] saturating sum");
        sb.push_back(model_sum(16'hFF00, 16'h0200));
        apply_stimulus(2, 16'hFF00, 4, 16'h0200, -1, -1, -1, 40);
        check_output("sat_margin_abs", bus.margin, 16'hFFFF);
        check_output("sat_overflow_abs", bus.overflow, 1);
        check_output("sat_mv_at", obs_mv_at, 6);

        $display("[TB] scan-risk timeout");
        sb.push_back(model_err(2'b01));
        apply_stimulus(-1, 16'h0000, -1, 16'h0000, -1, -1, -1, 40);
        check_output("srto_err_at", obs_err_at, 10);
        check_output("srto_sr_pulses", obs_sr_pulses, 1);
        check_output("srto_ims_pulses", obs_ims_pulses, 0);
        check_output("srto_busy", bus.busy, 0);

        $display("[TB] spread timeout");
        sb.push_back(model_err(2'b10));
        apply_stimulus(2, 16'h0011, -1, 16'h0000, -1, -1, -1, 40);
        check_output("imsto_err_at", obs_err_at, 12);
        check_output("imsto_ims_pulses", obs_ims_pulses, 1);

        $display("[TB] start while busy");
        sb.push_back(model_sum(16'h0120, 16'h0034));
        apply_stimulus(2, 16'h0120, 4, 16'h0034, 3, -1, -1, 40);
        check_output("brej_busy_reject", bus.busy_reject, 1);
        check_output("brej_sr_pulses", obs_sr_pulses, 1);
        check_output("brej_ims_pulses", obs_ims_pulses, 1);
        check_output("brej_mv_at", obs_mv_at, 6);

        $display("[TB] stray done inputs");
        bus.ims_done   = 1'b1;
        bus.ims_result = 16'h7777;
        tick();
        bus.ims_done = 1'b0;
        check_output("stray_idle_margin", bus.margin, 16'h0154);
        check_output("stray_idle_mv", bus.margin_valid, 1);
        check_output("stray_idle_busy", bus.busy, 0);
        sb.push_back(model_sum(16'h0100, 16'h0022));
        apply_stimulus(3, 16'h0100, 5, 16'h0022, -1, -1, 1, 40);
        check_output("stray_ims_start_at", obs_ims_start_at, 4);
        check_output("stray_mv_at", obs_mv_at, 7);
        check_output("stray_busy_reject_cleared", bus.busy_reject, 0);

        $display("[TB] abort with simultaneous start");
        apply_stimulus(2, 16'h0120, -1, 16'h0000, 5, 5, -1, 12);
        check_output("abort_mv", bus.margin_valid, 0);
        check_output("abort_err", bus.err, 0);
        check_output("abort_busy", bus.busy, 0);
        check_output("abort_sr_pulses", obs_sr_pulses, 1);
        check_output("abort_ims_pulses", obs_ims_pulses, 1);
        check_output("abort_no_result", obs_mv_at, -1);

        $display("[TB] rerun after abort");
        sb.push_back(model_sum(16'h0120, 16'h0034));
        apply_stimulus(2, 16'h0120, 4, 16'h0034, -1, -1, -1, 40);
        check_output("rerun_mv_at", obs_mv_at, 6);
        check_output("rerun_sr_pulses", obs_sr_pulses, 1);

        $display("[TB] abort while done");
        bus.cmd_abort = 1'b1;
        tick();
        bus.cmd_abort = 1'b0;
        check_output("abort_done_mv", bus.margin_valid, 0);
        check_output("abort_done_margin_kept", bus.margin, 16'h0154);

        $display("[TB] reset mid-sequence");
        bus.cmd_start = 1'b1;
        tick();
        bus.cmd_start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_output("midrst_margin", bus.margin, 0);
        check_output("midrst_busy", bus.busy, 0);
        check_output("midrst_err", bus.err, 0);
        late_pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.sr_start || bus.ims_start) late_pulses++;
        end
        check_output("midrst_no_pulses", late_pulses, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
